dnn_argmax_fix10: RTL and testbench
===================================

// Module: dnn_argmax_fix10
// PURPOSE
//  Downstream classifier stage for the fix10 sigmoid inference engine.
//  After the engine reports done, it walks the engine's 10-entry output
//  select port (out_idx -> out). It reads one score per cycle, then reports
//  the winning digit and its score with a valid flag. Replaces off-chip
//  readback of all ten scores with a single 4-bit class result.
// PARAMETERS
//  DATA_WIDTH   10  width of signed fixed-point score from engine
//  NUM_CLASSES  10  number of output neurons scanned (1..16)
//  IDX_WIDTH    4   width of out_idx / class_idx
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-low reset
//  start      in   1           one-cycle pulse; tie to engine done rise
//  out_idx    out  IDX_WIDTH   score select driven to engine out_idx
//  out        in   DATA_WIDTH  signed score from engine, combinational from out_idx
//  busy       out  1           high while scanning
//  valid      out  1           result valid; held until next start or reset
//  class_idx  out  IDX_WIDTH   index of maximum score
//  class_val  out  DATA_WIDTH  signed maximum score
//  margin     out  DATA_WIDTH+1 unsigned max minus second max (ARGMAX_MARGIN_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. out_idx, busy, valid, class_idx,
//    class_val and margin all 0. Reset mid-scan aborts the scan; no partial result.
//  - FSM states:
//    - IDLE: out_idx=0. start=1 -> SCAN with scan index 0.
//    - SCAN: out_idx=index; busy=1. Each edge samples out for the current
//      index. Index 0 loads best unconditionally. Later indices replace best
//      only if out > best (signed, strict).
//      Index==NUM_CLASSES-1 -> DONE and commit the result; else index+1.
//    - DONE: valid=1, busy=0, out_idx=0. start=1 -> SCAN, index 0, valid
//      drops on the same edge.
//  - Latency: start sampled at edge k; valid rises at edge k+NUM_CLASSES.
//    With defaults that is 10 cycles.
//  - start while in SCAN is ignored; the scan is not restarted.
//  - Ties: the lowest index wins because replacement is strict-greater.
//  - class_idx and class_val change only on entry to DONE. They are
//    stable at all other times, including during a new scan.
//  - Compare is full-width signed. The most negative score (-512) is a legal
//    winner when all scores are equal to it.
//  - out_idx is never driven with a value >= NUM_CLASSES.
// CONFIGURATION
//  ARGMAX_MARGIN_EN defined:
//    - Second-best score is tracked, and the margin port exists.
//    - Index 0 sets second=-2^(DATA_WIDTH-1).
//    - A new best moves the old best to second. Otherwise, out > second
//      updates second.
//    - margin = best - second, DATA_WIDTH+1 bits, committed on entry to DONE.
//    - margin resets to 0.
//    - NUM_CLASSES==1 gives margin = best + 2^(DATA_WIDTH-1).
//  ARGMAX_MARGIN_EN undefined: no second-best registers and no margin port;
//    all other behaviour is identical.
// TESTING
//  1. Scores {10,20,...,100}; start -> valid at k+10, class_idx=9, class_val=100,
//     margin=10.
//  2. All scores -512; start -> class_idx=0, class_val=-512, margin=0.
//  3. Score[3]=Score[7]=200, others 0 -> class_idx=3 (tie to lowest), margin=0.
//  4. Second start pulse at cycle k+4 during scan -> ignored; valid still at k+10.
//  5. Drop rst at cycle k+5, release, then start with new scores {5,0,...} ->
//     outputs 0 during reset, then class_idx=0, class_val=5.
//  6. Back-to-back: start in DONE -> valid drops the next edge; old
//     class_idx is held until the new result commits.

Source files
------------

// File: rtl/dnn_argmax_fix10_if.sv
// Bus between the fix10 argmax stage and its surroundings.
// master: engine/controller side (drives start and the selected score).
// slave : argmax stage (drives score select and the class result).
// margin is present only when ARGMAX_MARGIN_EN is defined.
interface dnn_argmax_fix10_if #(
    parameter int DATA_WIDTH = 10,
    parameter int IDX_WIDTH  = 4
);
    logic                         start;
    logic        [IDX_WIDTH-1:0]  out_idx;
    logic signed [DATA_WIDTH-1:0] out;
    logic                         busy;
    logic                         valid;
    logic        [IDX_WIDTH-1:0]  class_idx;
    logic signed [DATA_WIDTH-1:0] class_val;
`ifdef ARGMAX_MARGIN_EN
    logic        [DATA_WIDTH:0]   margin;

    modport master (
        output start, out,
        input  out_idx, busy, valid, class_idx, class_val, margin
    );

    modport slave (
        input  start, out,
        output out_idx, busy, valid, class_idx, class_val, margin
    );
`else
    modport master (
        output start, out,
        input  out_idx, busy, valid, class_idx, class_val
    );

    modport slave (
        input  start, out,
        output out_idx, busy, valid, class_idx, class_val
    );
`endif
endinterface

// File: rtl/dnn_argmax_fix10.sv
// Argmax classifier stage for the fix10 sigmoid inference engine.
// On start it walks the engine's score select (one score per cycle),
// keeps the strictly greatest signed score (lowest index wins ties) and
// commits the winning class index and score on entry to DONE.
// Optional feature macro: ARGMAX_MARGIN_EN adds second-best tracking and
// the margin output (best minus second best, unsigned, DATA_WIDTH+1 bits).
module dnn_argmax_fix10 #(
    parameter int DATA_WIDTH  = 10,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    dnn_argmax_fix10_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state_q;
    state_t                       state_d;
    logic        [IDX_WIDTH-1:0]  idx_q;
    logic        [IDX_WIDTH-1:0]  idx_d;
    logic                         commit;

    logic signed [DATA_WIDTH-1:0] best_q;
    logic signed [DATA_WIDTH-1:0] best_d;
    logic        [IDX_WIDTH-1:0]  best_idx_q;
    logic        [IDX_WIDTH-1:0]  best_idx_d;
    logic                         take;

    logic        [IDX_WIDTH-1:0]  class_idx_q;
    logic signed [DATA_WIDTH-1:0] class_val_q;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_WIDTH-1:0] second_q;
    logic signed [DATA_WIDTH-1:0] second_d;
    logic        [DATA_WIDTH:0]   margin_q;

    // Difference of two signed scores, sign-extended so it never wraps;
    // callers guarantee hi >= lo, so the result is non-negative.
    function automatic logic [DATA_WIDTH:0] calc_margin(
        input logic signed [DATA_WIDTH-1:0] hi,
        input logic signed [DATA_WIDTH-1:0] lo
    );
        logic signed [DATA_WIDTH:0] diff;
        diff = $signed({hi[DATA_WIDTH-1], hi}) - $signed({lo[DATA_WIDTH-1], lo});
        return $unsigned(diff);
    endfunction
`endif

    // Index 0 loads unconditionally; later scores must be strictly greater.
    assign take = (idx_q == '0) || (bus.out > best_q);

    // FSM next state, scan index and handshake outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        commit      = 1'b0;
        bus.out_idx = '0;
        bus.busy    = 1'b0;
        bus.valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                bus.out_idx = idx_q;
                bus.busy    = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    commit  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                bus.valid = 1'b1;
                if (bus.start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Running best (and second best) including the score sampled this cycle.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (take) begin
            best_d     = bus.out;
            best_idx_d = idx_q;
        end
`ifdef ARGMAX_MARGIN_EN
        second_d = second_q;
        if (idx_q == '0) begin
            second_d = MIN_SCORE;
        end else if (bus.out > best_q) begin
            second_d = best_q;
        end else if (bus.out > second_q) begin
            second_d = bus.out;
        end
`endif
    end

    // Control state and committed result; reset aborts any scan in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            class_idx_q <= '0;
            class_val_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            margin_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (commit) begin
                class_idx_q <= best_idx_d;
                class_val_q <= best_d;
`ifdef ARGMAX_MARGIN_EN
                margin_q    <= calc_margin(best_d, second_d);
`endif
            end
        end
    end

    // Scan accumulators; reloaded at index 0 so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == SCAN) begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    assign bus.class_idx = class_idx_q;
    assign bus.class_val = class_val_q;
`ifdef ARGMAX_MARGIN_EN
    assign bus.margin    = margin_q;
`endif

endmodule

// File: tb/tb_dnn_argmax_fix10.sv
// Directed testbench for dnn_argmax_fix10; models the engine's
// combinational score select with a small score table.
// Margin checks are compiled in only when ARGMAX_MARGIN_EN is defined.
module tb_dnn_argmax_fix10;

    logic clk;
    logic rst;
    logic signed [9:0] scores [0:15];
    int tests;
    int fails;

    dnn_argmax_fix10_if #(.DATA_WIDTH(10), .IDX_WIDTH(4)) bus ();

    dnn_argmax_fix10 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: score is combinational from the select.
    always_comb bus.out = scores[bus.out_idx];

    task automatic clear_scores();
        for (int i = 0; i < 16; i++) scores[i] = 10'sd0;
    endtask

    task automatic pulse_and_wait(output int lat);
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        clear_scores();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.out_idx !== 4'd0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%0b valid=%0b out_idx=%0d, want 0 0 0", bus.busy, bus.valid, bus.out_idx);
        end
        tests++;
        if (bus.class_idx !== 4'd0 || bus.class_val !== 10'sd0) begin
            fails++;
            $display("FAIL reset_result: class_idx=%0d class_val=%0d, want 0 0", bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd0) begin
            fails++;
            $display("FAIL reset_margin: got %0d want 0", bus.margin);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ramp();
        int lat;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 10'(10 * (i + 1));
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.out_idx !== 4'd0 || bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL ramp_scan_entry: busy=%0b out_idx=%0d valid=%0b, want 1 0 0", bus.busy, bus.out_idx, bus.valid);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.out_idx !== 4'd1) begin
            fails++;
            $display("FAIL ramp_out_idx: got %0d want 1", bus.out_idx);
        end
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        tests++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL ramp_latency: got %0d want 10", lat);
        end
        tests++;
        if (bus.class_idx !== 4'd9 || bus.class_val !== 10'sd100) begin
            fails++;
            $display("FAIL ramp_result: class_idx=%0d class_val=%0d, want 9 100", bus.class_idx, bus.class_val);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.out_idx !== 4'd0) begin
            fails++;
            $display("FAIL ramp_done_ctrl: busy=%0b out_idx=%0d, want 0 0", bus.busy, bus.out_idx);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd10) begin
            fails++;
            $display("FAIL ramp_margin: got %0d want 10", bus.margin);
        end
`endif
    endtask

    task automatic test_all_min();
        int lat;
        logic held;
        held = 1'b1;
        for (int i = 0; i < 10; i++) scores[i] = -10'sd512;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.class_idx !== 4'd9 || bus.class_val !== 10'sd100) held = 1'b0;
        end
        tests++;
        if (held !== 1'b1) begin
            fails++;
            $display("FAIL min_hold_old: old result not held during scan, got %0b want 1", held);
        end
        tests++;
        if (lat !== 10 || bus.class_idx !== 4'd0 || bus.class_val !== -10'sd512) begin
            fails++;
            $display("FAIL min_result: lat=%0d class_idx=%0d class_val=%0d, want 10 0 -512", lat, bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd0) begin
            fails++;
            $display("FAIL min_margin: got %0d want 0", bus.margin);
        end
`endif
    endtask

    task automatic test_tie();
        int lat;
        clear_scores();
        scores[3] = 10'sd200;
        scores[7] = 10'sd200;
        pulse_and_wait(lat);
        tests++;
        if (lat !== 10 || bus.class_idx !== 4'd3 || bus.class_val !== 10'sd200) begin
            fails++;
            $display("FAIL tie_result: lat=%0d class_idx=%0d class_val=%0d, want 10 3 200", lat, bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd0) begin
            fails++;
            $display("FAIL tie_margin: got %0d want 0", bus.margin);
        end
`endif
    endtask

    task automatic test_start_ignored();
        int lat;
        clear_scores();
        scores[0] = -10'sd5;  scores[1] = 10'sd7;  scores[2] = 10'sd300;
        scores[3] = -10'sd100; scores[4] = 10'sd299; scores[5] = 10'sd0;
        scores[6] = 10'sd1;   scores[7] = 10'sd2;  scores[8] = 10'sd3;
        scores[9] = 10'sd4;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 3);
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL restart_latency: got %0d want 10", lat);
        end
        tests++;
        if (bus.class_idx !== 4'd2 || bus.class_val !== 10'sd300) begin
            fails++;
            $display("FAIL restart_result: class_idx=%0d class_val=%0d, want 2 300", bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd1) begin
            fails++;
            $display("FAIL restart_margin: got %0d want 1", bus.margin);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.out_idx !== 4'd0 ||
            bus.class_idx !== 4'd0 || bus.class_val !== 10'sd0) begin
            fails++;
            $display("FAIL midreset_async: busy=%0b valid=%0b out_idx=%0d class_idx=%0d class_val=%0d, want all 0",
                     bus.busy, bus.valid, bus.out_idx, bus.class_idx, bus.class_val);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: valid=%0b busy=%0b, want 0 0", bus.valid, bus.busy);
        end
        clear_scores();
        scores[0] = 10'sd5;
        pulse_and_wait(lat);
        tests++;
        if (lat !== 10 || bus.class_idx !== 4'd0 || bus.class_val !== 10'sd5) begin
            fails++;
            $display("FAIL midreset_result: lat=%0d class_idx=%0d class_val=%0d, want 10 0 5", lat, bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd5) begin
            fails++;
            $display("FAIL midreset_margin: got %0d want 5", bus.margin);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        logic held;
        held = 1'b1;
        for (int i = 0; i < 10; i++) scores[i] = 10'sd1;
        scores[6] = 10'sd50;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_valid_drop: valid=%0b busy=%0b, want 0 1", bus.valid, bus.busy);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.class_idx !== 4'd0 || bus.class_val !== 10'sd5) held = 1'b0;
        end
        tests++;
        if (held !== 1'b1) begin
            fails++;
            $display("FAIL b2b_hold_old: old result not held during scan, got %0b want 1", held);
        end
        tests++;
        if (lat !== 10 || bus.class_idx !== 4'd6 || bus.class_val !== 10'sd50) begin
            fails++;
            $display("FAIL b2b_result: lat=%0d class_idx=%0d class_val=%0d, want 10 6 50", lat, bus.class_idx, bus.class_val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus.margin !== 11'd49) begin
            fails++;
            $display("FAIL b2b_margin: got %0d want 49", bus.margin);
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ramp();
        test_all_min();
        test_tie();
        test_start_ignored();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
